// File: rtl/pixel_win_pkg.sv
// Shared widths and 3x3 window tap indices for the pixel window block and its
// downstream filters; taps are sliced from win_data as win_data[P*DW +: DW].
package pixel_win_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IMG_WIDTH_DFLT  = 250;
  localparam int IMG_HEIGHT_DFLT = 200;
  localparam int COL_W = idx_w(IMG_WIDTH_DFLT);
  localparam int ROW_W = idx_w(IMG_HEIGHT_DFLT);

  // Tap index = row*3 + col, row 0 is oldest line, col 0 is leftmost.
  localparam int P00 = 0;
  localparam int P01 = 1;
  localparam int P02 = 2;
  localparam int P10 = 3;
  localparam int P11 = 4;
  localparam int P12 = 5;
  localparam int P20 = 6;
  localparam int P21 = 7;
  localparam int P22 = 8;
  localparam int N_TAPS = 9;

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line buffer: combinational read of the addressed word, write on
// the clock edge, so a same-cycle access returns the old contents.
module line_buffer_ram
  import pixel_win_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 250,
  parameter int ADDR_W     = idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/pixel_window_3x3.sv
// Builds a 3x3 window per accepted raster pixel from two line buffers.
// Define WIN_COORD_EN to add win_col/win_row (centre pixel coordinates).
module pixel_window_3x3
  import pixel_win_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 250,
  parameter int IMG_HEIGHT = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         win_valid,
  output logic [N_TAPS*DATA_WIDTH-1:0] win_data,
  output logic                         frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [idx_w(IMG_WIDTH)-1:0]  win_col,
  output logic [idx_w(IMG_HEIGHT)-1:0] win_row
`endif
);

  localparam int CW = idx_w(IMG_WIDTH);
  localparam int RW = idx_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [N_TAPS-1:0][DATA_WIDTH-1:0] tap_q, tap_d;
  logic [N_TAPS-1:0][DATA_WIDTH-1:0] win_data_q, win_data_d;
  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(CW)) u_lb0 (
    .clk(clk), .we(in_valid), .addr(cur_col), .wdata(in_data), .rdata(lb0_rd)
  );

  line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(CW)) u_lb1 (
    .clk(clk), .we(in_valid), .addr(cur_col), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  // Start-of-frame overrides the counters so a resync lands on (0,0).
  always_comb begin
    cur_col      = (in_valid && in_sof) ? '0 : col_q;
    cur_row      = (in_valid && in_sof) ? '0 : row_q;
    col_d        = col_q;
    row_d        = row_q;
    tap_d        = tap_q;
    win_valid_d  = 1'b0;
    win_data_d   = win_data_q;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      for (int r = 0; r < 3; r++) begin
        tap_d[r*3 + 0] = tap_q[r*3 + 1];
        tap_d[r*3 + 1] = tap_q[r*3 + 2];
      end
      tap_d[P22] = in_data;
      tap_d[P12] = lb0_rd;
      tap_d[P02] = lb1_rd;
      if (cur_row >= ROW_TWO && cur_col >= COL_TWO) begin
        win_valid_d = 1'b1;
        win_data_d  = tap_d;
      end
      frame_done_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      tap_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      tap_q        <= tap_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign frame_done = frame_done_q;

`ifdef WIN_COORD_EN
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;

  always_comb begin
    win_col_d = win_col_q;
    win_row_d = win_row_q;
    if (in_valid && cur_row >= ROW_TWO && cur_col >= COL_TWO) begin
      win_col_d = cur_col - 1'b1;
      win_row_d = cur_row - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_col_q <= '0;
      win_row_q <= '0;
    end else begin
      win_col_q <= win_col_d;
      win_row_q <= win_row_d;
    end
  end

  assign win_col = win_col_q;
  assign win_row = win_row_q;
`endif

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Bench for pixel_window_3x3 on a 5x4 image: directed frames plus random
// gaps/data/resyncs, all outputs compared every cycle to an image-array model.
module tb_pixel_window_3x3;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic win_valid, frame_done;
  logic [9*DW-1:0] win_data;
`ifdef WIN_COORD_EN
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
`endif

  pixel_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .win_valid(win_valid), .win_data(win_data), .frame_done(frame_done)
`ifdef WIN_COORD_EN
    , .win_col(win_col), .win_row(win_row)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the current frame as a 2D image; a window is read straight
  // out of the image around the pixel just written.
  logic [DW-1:0] img [H][W];
  int m_col = 0, m_row = 0;
  logic m_valid = 1'b0, m_fd = 1'b0;
  logic [71:0] m_data = '0;
  int m_wcol = 0, m_wrow = 0;

  int wins_seen = 0;
  logic [71:0] first_win, last_win;

  task automatic model_reset();
    m_col = 0; m_row = 0; m_valid = 1'b0; m_fd = 1'b0; m_data = '0;
    m_wcol = 0; m_wrow = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [DW-1:0] d);
    int r, c;
    m_valid = 1'b0;
    m_fd = 1'b0;
    if (!v) return;
    if (s) begin r = 0; c = 0; end else begin r = m_row; c = m_col; end
    img[r][c] = d;
    if (r >= 2 && c >= 2) begin
      m_valid = 1'b1;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          m_data[(rr*3 + cc)*DW +: DW] = img[r-2+rr][c-2+cc];
      m_wcol = c - 1;
      m_wrow = r - 1;
    end
    m_fd = (r == H-1) && (c == W-1);
    m_col = (c + 1) % W;
    m_row = (c == W-1) ? (r + 1) % H : r;
  endtask

  task automatic check_outputs();
    check_val("win_valid", 72'(win_valid), 72'(m_valid));
    check_val("frame_done", 72'(frame_done), 72'(m_fd));
    check_val("win_data", win_data, m_data);
`ifdef WIN_COORD_EN
    check_val("win_col", 72'(win_col), 72'(m_wcol));
    check_val("win_row", 72'(win_row), 72'(m_wrow));
`endif
    if (win_valid) begin
      if (wins_seen == 0) first_win = win_data;
      last_win = win_data;
      wins_seen++;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, (i == 0), DW'(base + i));
      if (gaps) step(1'b0, 1'b0, DW'($urandom));
    end
    idle(2);
  endtask

  initial begin
    #12;
    check_val("reset_valid", 72'(win_valid), 72'(0));
    check_val("reset_data", win_data, 72'(0));
    check_val("reset_fd", 72'(frame_done), 72'(0));
    @(negedge clk); rst = 1'b1;

    // Continuous frame
    wins_seen = 0;
    send_frame(0, 1'b0);
    check_val("t1_nwin", 72'(wins_seen), 72'(6));
    check_val("t1_first", first_win,
              {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});
    check_val("t1_last", last_win,
              {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7});

    // Same frame with in_valid low every other cycle
    wins_seen = 0;
    send_frame(0, 1'b1);
    check_val("t2_nwin", 72'(wins_seen), 72'(6));
    check_val("t2_first", first_win,
              {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});

    // Back-to-back frames
    for (int i = 0; i < W*H; i++) step(1'b1, (i == 0), DW'(i));
    wins_seen = 0;
    for (int i = 0; i < W*H; i++) step(1'b1, (i == 0), DW'(100 + i));
    idle(1);
    check_val("t3_nwin", 72'(wins_seen), 72'(6));
    check_val("t3_first", first_win,
              {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100});

    // Mid-frame resync at idx 8
    for (int i = 0; i < 8; i++) step(1'b1, (i == 0), DW'(i));
    wins_seen = 0;
    for (int i = 0; i < W*H; i++) step(1'b1, (i == 0), DW'(200 + i));
    idle(1);
    check_val("t4_nwin", 72'(wins_seen), 72'(6));
    check_val("t4_first", first_win,
              {8'd212, 8'd211, 8'd210, 8'd207, 8'd206, 8'd205, 8'd202, 8'd201, 8'd200});

    // Reset after idx 13, then restart without sof
    for (int i = 0; i < 14; i++) step(1'b1, (i == 0), DW'(i));
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_val("t5_rst_valid", 72'(win_valid), 72'(0));
    check_val("t5_rst_data", win_data, 72'(0));
    check_val("t5_rst_fd", 72'(frame_done), 72'(0));
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    wins_seen = 0;
    for (int i = 0; i < W*H; i++) step(1'b1, 1'b0, DW'(i));
    idle(1);
    check_val("t5_nwin", 72'(wins_seen), 72'(6));
    check_val("t5_last", last_win,
              {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7});

    // Random data, random gaps, occasional mid-frame resync
    for (int f = 0; f < 8; f++) begin
      int i = 0;
      while (i < W*H) begin
        if ($urandom_range(0, 3) == 0) begin
          step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
        end else begin
          if (i > 0 && $urandom_range(0, 39) == 0) i = 0;
          step(1'b1, (i == 0), DW'($urandom));
          i++;
        end
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
